jk_stim_checker: RTL and testbench
==================================

Name: jk_stim_checker

Overview:
- Synthesizable driver/checker for the other end of the JK flip-flop interface (J, K, sync_reset in; Q out).
- Takes a target Q sequence and computes the J/K values from the JK excitation table. It drives those values into the flop, samples the flop's Q, and reports the mismatches.
- Used for on-chip self-test of JK flops and as a reusable bench component.

Parameters:
- LEN, 8: number of pattern steps. Must be ≥ 2.
- DC_MODE, 0: don't-care resolution. 0 resolves x to 0 (hold/set/reset form). 1 resolves x to 1 (toggle form).
- CW, $clog2(LEN+1): width of err_count.
- IW, $clog2(LEN): width of first_err_idx.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run. Accepted only in IDLE.
- pattern  in  LEN  target Q sequence. Bit 0 is the first step. Captured on the accepted start.
- J  out  1  J input to the flop under test (registered).
- K  out  1  K input to the flop under test (registered).
- dut_reset  out  1  drives the flop's sync_reset (registered).
- Q  in  1  Q output of the flop under test.
- busy  out  1  high from INIT through CHECK.
- done  out  1  one-cycle pulse when the run completes.
- pass  out  1  high when err_count is 0. Valid from done until the next accepted start.
- err_count  out  CW  number of mismatching steps.
- first_err_idx  out  IW  index of the lowest mismatching step. Holds 0 if there is no error.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE.
  - J=0, K=0, dut_reset=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0.
  - The captured pattern and step counters are cleared.
- States are IDLE, INIT, RUN, CHECK, DONE.
- IDLE → INIT on start=1 at edge s.
  - Capture pattern. dut_reset<=1, busy<=1, err_count<=0, pass<=0, first_err_idx<=0.
- INIT → RUN at edge s+1.
  - dut_reset<=0.
  - Drive step 0 with prev=0, tgt=pattern[0]. The flop resets to Q=0 on this edge.
- RUN: at edge s+1+i, J/K<=excite(prev=pattern[i-1], tgt=pattern[i]).
  - Excitation uses the prior target bit, not the observed Q, so J/K are independent of flop faults.
  - The flop updates Q=pattern[i] at edge s+2+i.
  - After the last drive (i=LEN-1), J/K<=0 (hold) and state moves to CHECK.
- Compare: at edge s+3+i (i=0..LEN-1), sample Q against pattern[i].
  - On a mismatch, increment err_count. If this is the first mismatch, set first_err_idx<=i.
  - Compares overlap the tail of RUN and complete in CHECK.
  - The last compare is at edge s+2+LEN. On that edge: state→DONE, done<=1, busy<=0, pass<=(final err_count==0).
- DONE → IDLE on the next edge. done<=0. Results hold.
- start during INIT, RUN, CHECK or DONE is ignored and the pattern is not recaptured.
- Excitation table (prev→tgt : J K):
  - DC_MODE=0: 0→0: 0 0; 0→1: 1 0; 1→0: 0 1; 1→1: 0 0.
  - DC_MODE=1: 0→0: 0 1; 0→1: 1 1; 1→0: 1 1; 1→1: 1 0.
- err_count saturates at LEN and cannot overflow by construction.
- rst_n asserted mid-run aborts immediately to reset values. No done pulse is produced.
- Total run: busy is high for LEN+2 cycles; done is at edge s+2+LEN.

Decomposition:
- Package jk_test_pkg holds:
  - the state enum/localparams (IDLE=0, INIT=1, RUN=2, CHECK=3, DONE=4);
  - the DC_MODE constants DC_ZERO=0 and DC_TOGGLE=1.
- Sub-module jk_excite (combinational): inputs prev, tgt; parameter DC_MODE; outputs J, K. It is reused by other flop drivers.
- The top module holds the FSM, the pattern shift register, the step and compare counters, and the result registers.

Test Plan:
1. LEN=8, DC_MODE=0, pattern=8'b1010_1100, ideal JK flop attached.
   - Required: done at edge s+10, busy for 10 cycles, pass=1, err_count=0, first_err_idx=0.
2. Same run with a trace check.
   - Required J/K per step: (0,0),(0,0),(1,0),(0,0),(0,1),(1,0),(0,1),(1,0). dut_reset high for exactly one cycle after start. J=K=0 after the last step.
3. DC_MODE=1, same pattern.
   - Required J/K: (0,1),(0,1),(1,1),(1,0),(1,1),(1,1),(1,1),(1,1). pass=1.
4. Fault: Q stuck-at-0, pattern=8'b1010_1100.
   - Required: err_count=4, first_err_idx=2, pass=0.
   - Second fault: Q inverted. Required: err_count=8, first_err_idx=0.
5. start pulsed during RUN with a different pattern.
   - Required: ignored; results match the first pattern. A new start after done yields a fresh run with err_count reset.
6. rst_n low at edge s+5.
   - Required: J=K=0, dut_reset=0, busy=0, no done pulse. A subsequent run with pattern=8'hFF gives pass=1.

Source files
------------

// File: rtl/jk_stim_checker_pkg.sv
// Shared constants for the JK flop stimulus/checker block:
// FSM state encodings and don't-care resolution modes.
package jk_test_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int DC_ZERO   = 0;
  localparam int DC_TOGGLE = 1;

endpackage

// File: rtl/jk_stim_checker_if.sv
// Connection between the stimulus/checker and the JK flop under test.
// master = checker side (drives J/K/sync reset), slave = flop side (drives Q).
interface jk_stim_checker_if;

  logic J;
  logic K;
  logic dut_reset;
  logic Q;

  modport master (output J, output K, output dut_reset, input Q);
  modport slave  (input J, input K, input dut_reset, output Q);

endinterface

// File: rtl/jk_stim_checker_excite.sv
// JK excitation table: J/K needed to move a flop from prev to tgt.
// DC_MODE picks how the table's don't-care entries are resolved.
module jk_excite
  import jk_test_pkg::*;
#(
  parameter int DC_MODE = DC_ZERO
) (
  input  logic prev,
  input  logic tgt,
  output logic J,
  output logic K
);

  always_comb begin
    if (DC_MODE == DC_TOGGLE) begin
      J = prev | tgt;
      K = ~(prev & tgt);
    end else begin
      J = ~prev & tgt;
      K = prev & ~tgt;
    end
  end

endmodule

// File: rtl/jk_stim_checker.sv
// Drives a target Q sequence into a JK flop via its excitation values,
// then compares the flop's Q two cycles after each drive and tallies mismatches.
//
// state | meaning
// IDLE  | waiting for start, results held
// INIT  | flop held in sync reset, pattern captured
// RUN   | one J/K step driven per cycle
// CHECK | J/K parked at hold, trailing compares drain
// DONE  | one-cycle done pulse, then back to IDLE
module jk_stim_checker
  import jk_test_pkg::*;
#(
  parameter int LEN     = 8,
  parameter int DC_MODE = DC_ZERO,
  parameter int CW      = $clog2(LEN + 1),
  parameter int IW      = $clog2(LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN-1:0]      pattern,
  jk_stim_checker_if.master   jk,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CW-1:0]       err_count,
  output logic [IW-1:0]       first_err_idx
);

  logic [2:0]     state_q, state_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic           prev_q, prev_d;
  logic [CW-1:0]  step_q, step_d;
  logic [1:0]     exp_q, exp_d;
  logic [1:0]     expv_q, expv_d;
  logic [IW-1:0]  cmp_q, cmp_d;
  logic           j_q, j_d;
  logic           k_q, k_d;
  logic           drst_q, drst_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [CW-1:0]  err_q, err_d;
  logic [IW-1:0]  ferr_q, ferr_d;

  logic exc_j;
  logic exc_k;

  // Excitation is taken from the previous target bit, never from observed Q,
  // so a faulty flop cannot disturb the stimulus.
  jk_excite #(.DC_MODE(DC_MODE)) u_excite (
    .prev (prev_q),
    .tgt  (pat_q[0]),
    .J    (exc_j),
    .K    (exc_k)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    prev_d  = prev_q;
    step_d  = step_q;
    exp_d   = {exp_q[0], pat_q[0]};
    expv_d  = {expv_q[0], 1'b0};
    cmp_d   = cmp_q;
    j_d     = j_q;
    k_d     = k_q;
    drst_d  = drst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ferr_d  = ferr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          pat_d   = pattern;
          prev_d  = 1'b0;
          step_d  = '0;
          cmp_d   = '0;
          j_d     = 1'b0;
          k_d     = 1'b0;
          drst_d  = 1'b1;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          ferr_d  = '0;
        end
      end
      INIT, RUN: begin
        drst_d = 1'b0;
        if (step_q != CW'(LEN)) begin
          j_d       = exc_j;
          k_d       = exc_k;
          prev_d    = pat_q[0];
          pat_d     = pat_q >> 1;
          step_d    = step_q + 1'b1;
          expv_d[0] = 1'b1;
          state_d   = RUN;
        end else begin
          j_d     = 1'b0;
          k_d     = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The target bit reaches stage 1 exactly when the flop should be showing it.
    if (expv_q[1]) begin
      if (jk.Q != exp_q[1]) begin
        if (err_q != CW'(LEN)) err_d = err_q + 1'b1;
        if (err_q == '0)       ferr_d = cmp_q;
      end
      cmp_d = cmp_q + 1'b1;
      if (cmp_q == IW'(LEN - 1)) begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_d == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      prev_q  <= 1'b0;
      step_q  <= '0;
      exp_q   <= '0;
      expv_q  <= '0;
      cmp_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      drst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      prev_q  <= prev_d;
      step_q  <= step_d;
      exp_q   <= exp_d;
      expv_q  <= expv_d;
      cmp_q   <= cmp_d;
      j_q     <= j_d;
      k_q     <= k_d;
      drst_q  <= drst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  assign jk.J          = j_q;
  assign jk.K          = k_q;
  assign jk.dut_reset  = drst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = ferr_q;

endmodule

// File: tb/tb_jk_stim_checker.sv
// Bench for jk_stim_checker: two instances (hold/set/reset and toggle forms),
// each driving a behavioural JK flop with optional output faults.
module tb_jk_stim_checker;
  import jk_test_pkg::*;

  localparam int LEN = 8;
  localparam int CW  = $clog2(LEN + 1);
  localparam int IW  = $clog2(LEN);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           start_w [2];
  logic [LEN-1:0] pat_w   [2];
  logic           busy_w  [2];
  logic           done_w  [2];
  logic           pass_w  [2];
  logic [CW-1:0]  err_w   [2];
  logic [IW-1:0]  ferr_w  [2];
  logic           j_w     [2];
  logic           k_w     [2];
  logic           drst_w  [2];
  int             flt     [2];

  int checks = 0;
  int errors = 0;

  jk_stim_checker_if bus0 ();
  jk_stim_checker_if bus1 ();

  jk_stim_checker #(.LEN(LEN), .DC_MODE(DC_ZERO)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .pattern(pat_w[0]), .jk(bus0),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .first_err_idx(ferr_w[0])
  );

  jk_stim_checker #(.LEN(LEN), .DC_MODE(DC_TOGGLE)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .pattern(pat_w[1]), .jk(bus1),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .first_err_idx(ferr_w[1])
  );

  // Behavioural JK flops with sync reset; fault 1 = Q stuck-at-0, 2 = Q inverted.
  logic q0 = 1'b0;
  logic q1 = 1'b0;
  always @(posedge clk) begin
    if (bus0.dut_reset) q0 <= 1'b0;
    else case ({bus0.J, bus0.K})
      2'b01: q0 <= 1'b0;
      2'b10: q0 <= 1'b1;
      2'b11: q0 <= ~q0;
      default: ;
    endcase
  end
  always @(posedge clk) begin
    if (bus1.dut_reset) q1 <= 1'b0;
    else case ({bus1.J, bus1.K})
      2'b01: q1 <= 1'b0;
      2'b10: q1 <= 1'b1;
      2'b11: q1 <= ~q1;
      default: ;
    endcase
  end
  assign bus0.Q = (flt[0] == 1) ? 1'b0 : (flt[0] == 2) ? ~q0 : q0;
  assign bus1.Q = (flt[1] == 1) ? 1'b0 : (flt[1] == 2) ? ~q1 : q1;

  assign j_w[0] = bus0.J;  assign k_w[0] = bus0.K;  assign drst_w[0] = bus0.dut_reset;
  assign j_w[1] = bus1.J;  assign k_w[1] = bus1.K;  assign drst_w[1] = bus1.dut_reset;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Excitation table written out row by row.
  function automatic logic [1:0] exc(input int mode, input logic p, input logic t);
    logic [1:0] r;
    if (mode == DC_ZERO) begin
      case ({p, t})
        2'b00: r = 2'b00;
        2'b01: r = 2'b10;
        2'b10: r = 2'b01;
        default: r = 2'b00;
      endcase
    end else begin
      case ({p, t})
        2'b00: r = 2'b01;
        2'b01: r = 2'b11;
        2'b10: r = 2'b11;
        default: r = 2'b10;
      endcase
    end
    return r;
  endfunction

  // One complete run on instance w; mode of instance w equals w.
  task automatic run(input int w, input logic [LEN-1:0] pat, input int fault,
                     input bit trace, input bit midstart, input logic [LEN-1:0] alt);
    int exp_err = 0;
    int exp_first = 0;
    int dones = 0;
    int busy_cnt = 0;
    logic obs_bit;
    logic prev;
    logic [1:0] jk_exp;
    for (int i = 0; i < LEN; i++) begin
      obs_bit = (fault == 1) ? 1'b0 : (fault == 2) ? ~pat[i] : pat[i];
      if (obs_bit != pat[i]) begin
        if (exp_err == 0) exp_first = i;
        exp_err++;
      end
    end
    flt[w] = fault;
    @(negedge clk);
    pat_w[w]   = pat;
    start_w[w] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_w[w] = 1'b0;
    pat_w[w]   = ~pat;
    busy_cnt += int'(busy_w[w]);
    if (trace) begin
      chk("dut_reset_c0", drst_w[w], 1'b1);
      chk("busy_c0", busy_w[w], 1'b1);
    end
    for (int c = 1; c <= LEN + 3; c++) begin
      @(negedge clk);
      busy_cnt += int'(busy_w[w]);
      dones    += int'(done_w[w]);
      if (trace) begin
        chk("dut_reset_low", drst_w[w], 1'b0);
        chk("done_timing", done_w[w], (c == LEN + 2));
        if (c <= LEN) begin
          prev   = (c == 1) ? 1'b0 : pat[c-2];
          jk_exp = exc(w, prev, pat[c-1]);
        end else begin
          jk_exp = 2'b00;
        end
        chk("jk_step", {j_w[w], k_w[w]}, jk_exp);
        if (c == LEN + 1) chk("pass_cleared", pass_w[w], 1'b0);
      end
      if (c == LEN + 2) begin
        chk("err_count", err_w[w], exp_err);
        chk("first_err_idx", ferr_w[w], exp_first);
        chk("pass", pass_w[w], (exp_err == 0));
      end
      if (midstart && c == 3) begin
        pat_w[w]   = alt;
        start_w[w] = 1'b1;
      end
      if (midstart && c == 4) start_w[w] = 1'b0;
    end
    chk("done_pulses", dones, 1);
    chk("busy_cycles", busy_cnt, LEN + 2);
    chk("err_hold", err_w[w], exp_err);
  endtask

  initial begin
    logic [LEN-1:0] rp;
    int rw;
    int rf;
    start_w[0] = 1'b0; start_w[1] = 1'b0;
    pat_w[0] = '0; pat_w[1] = '0;
    flt[0] = 0; flt[1] = 0;

    #1;
    for (int w = 0; w < 2; w++) begin
      chk("rst_j", j_w[w], 1'b0);
      chk("rst_k", k_w[w], 1'b0);
      chk("rst_dut_reset", drst_w[w], 1'b0);
      chk("rst_busy", busy_w[w], 1'b0);
      chk("rst_done", done_w[w], 1'b0);
      chk("rst_pass", pass_w[w], 1'b0);
      chk("rst_err", err_w[w], 0);
      chk("rst_ferr", ferr_w[w], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed: ideal flop with trace, both don't-care forms.
    run(0, 8'b1010_1100, 0, 1'b1, 1'b0, '0);
    run(1, 8'b1010_1100, 0, 1'b1, 1'b0, '0);

    // Faults: stuck-at-0 and inverted Q.
    run(0, 8'b1010_1100, 1, 1'b1, 1'b0, '0);
    run(0, 8'b1010_1100, 2, 1'b0, 1'b0, '0);
    run(1, 8'b1010_1100, 2, 1'b0, 1'b0, '0);

    // start mid-run with another pattern and a faulty flop is ignored; next run is fresh.
    run(0, 8'b1010_1100, 1, 1'b1, 1'b1, 8'b0101_0011);
    run(0, 8'b0101_0011, 0, 1'b1, 1'b0, '0);

    // Abort with rst_n low across edge s+5.
    @(negedge clk);
    pat_w[0] = 8'b1010_1100;
    start_w[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy_w[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_j", j_w[0], 1'b0);
    chk("abort_k", k_w[0], 1'b0);
    chk("abort_dut_reset", drst_w[0], 1'b0);
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_done", done_w[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int dn = 0;
      for (int c = 0; c < LEN + 4; c++) begin
        @(negedge clk);
        dn += int'(done_w[0]) + int'(busy_w[0]);
      end
      chk("abort_no_done", dn, 0);
    end
    run(0, 8'hFF, 0, 1'b1, 1'b0, '0);

    // Randomized runs against the model.
    for (int n = 0; n < 16; n++) begin
      rp = LEN'($urandom);
      rw = int'($urandom_range(0, 1));
      rf = int'($urandom_range(0, 2));
      run(rw, rp, rf, 1'b1, (n % 4 == 3), LEN'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
